// File: rtl/operand_loader_if.sv
// Operand-loader bus: upstream beat handshake, downstream operand-set handshake,
// error pulse and transfer counter.
// master = the side that feeds beats and consumes operand sets; slave = the loader.
interface operand_loader_if #(parameter int WIDTH = 4);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_1;
  logic [WIDTH-1:0] out_2;
  logic             out_3;
  logic             err;
  logic [7:0]       op_count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_1, out_2, out_3, err, op_count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_1, out_2, out_3, err, op_count
  );
endinterface

// File: rtl/operand_loader.sv
// operand_loader: assembles three WIDTH-bit beats (A, B, C) into a registered
// operand set {out_1 = A, out_2 = B, out_3 = C[0]} held until downstream takes it.
// Beat A of the next group may be captured on the same edge as the transfer.
// Optional macro OPERAND_LOADER_TIMEOUT_EN builds an idle counter that drops a
// stalled partial group (in S_B/S_C) after TIMEOUT idle cycles and pulses err.
module operand_loader #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  operand_loader_if.slave bus
);

  typedef enum logic [1:0] {S_A, S_B, S_C, S_OUT} state_t;

  state_t           state, nxt;
  logic             acc, xfer, to_fire;
  logic [WIDTH-1:0] op1_q, op2_q;
  logic             op3_q;
  logic [7:0]       cnt_q;
  logic             err_q;

  // in_ready is the only combinational output: a full stage frees up when downstream takes it
  assign bus.in_ready  = (state != S_OUT) || bus.out_ready;
  assign bus.out_valid = (state == S_OUT);
  assign bus.out_1     = op1_q;
  assign bus.out_2     = op2_q;
  assign bus.out_3     = op3_q;
  assign bus.err       = err_q;
  assign bus.op_count  = cnt_q;

  assign acc  = bus.in_valid && ((state != S_OUT) || bus.out_ready);
  assign xfer = (state == S_OUT) && bus.out_ready;

`ifdef OPERAND_LOADER_TIMEOUT_EN
  localparam int             CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] idle_q;
  logic          waiting;

  assign waiting = (state == S_B) || (state == S_C);
  // an accepted beat always beats the timeout on the same edge
  assign to_fire = waiting && !acc && (idle_q == LAST);

  // idle counter runs only mid-group; err is the registered drop event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= to_fire;
      if (acc || !waiting || to_fire) idle_q <= '0;
      else                            idle_q <= idle_q + 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign to_fire        = 1'b0;
  assign err_q          = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_A;
    else     state <= nxt;
  end

  // next-state: beats advance A->B->C->OUT; transfer with a beat skips straight to S_B
  always_comb begin
    nxt = state;
    case (state)
      S_A:   if (acc) nxt = S_B;
      S_B:   if (acc) nxt = S_C;   else if (to_fire) nxt = S_A;
      S_C:   if (acc) nxt = S_OUT; else if (to_fire) nxt = S_A;
      S_OUT: if (xfer) nxt = acc ? S_B : S_A;
      default: nxt = S_A;
    endcase
  end

  // operand capture; unloaded fields keep stale values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op1_q <= '0;
      op2_q <= '0;
      op3_q <= 1'b0;
    end else if (acc) begin
      case (state)
        S_A, S_OUT: op1_q <= bus.in_data;
        S_B:        op2_q <= bus.in_data;
        S_C:        op3_q <= bus.in_data[0];
        default:    ;
      endcase
    end
  end

  // completed-transfer counter, natural 8-bit wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt_q <= '0;
    else if (xfer) cnt_q <= cnt_q + 8'd1;
  end

endmodule

// File: doc/operand_loader.md
# operand_loader

Upstream operand-staging stage for the nibble-wide combinational datapath (AND/OR, mask and select logic). It accepts a serial stream of WIDTH-bit beats over a valid/ready handshake and assembles each group of three beats into a first operand, a second operand and a select bit. It presents the group as a registered, stable operand set with its own valid/ready handshake. It also drops stalled partial groups on timeout and counts completed operations.

## Interface
Parameters:
- `WIDTH`, 4, operand width in bits (≥1)
- `TIMEOUT`, 15, idle cycles tolerated mid-group before the partial group is dropped (≥1)

Ports:
- `clk`  input  1  single clock, rising edge
- `rst`  input  1  reset, asynchronous, active-high
- `in_valid`  input  1  upstream beat valid
- `in_ready`  output  1  stage can accept a beat
- `in_data`  input  WIDTH  beat payload
- `out_valid`  output  1  operand set valid
- `out_ready`  input  1  downstream accepts operand set
- `out_1`  output  WIDTH  first operand (beat A)
- `out_2`  output  WIDTH  second operand (beat B)
- `out_3`  output  1  select bit (bit 0 of beat C)
- `err`  output  1  one-cycle pulse: partial group dropped
- `op_count`  output  8  completed output transfers, wraps

## Operation
- States: S_A (await beat A), S_B (await B), S_C (await C), S_OUT (holding operand set).
- Beat accepted when `in_valid && in_ready`. Output transferred when `out_valid && out_ready`.
- `in_ready` = (state != S_OUT) || `out_ready`. `out_valid` = (state == S_OUT).
- Transitions:
  - S_A: on accept → capture `in_data` into `out_1`, go to S_B.
  - S_B: on accept → capture into `out_2`, go to S_C.
  - S_C: on accept → capture `in_data[0]` into `out_3`, go to S_OUT. Bits [WIDTH-1:1] are ignored.
  - S_OUT with transfer and no beat → S_A.
  - S_OUT with transfer and a beat in the same cycle → capture the beat as the new `out_1`, go to S_B.
  - S_OUT without transfer → hold.
- `out_1`, `out_2` and `out_3` are stable while `out_valid && !out_ready`. `out_2` and `out_3` keep their stale values until overwritten.
- `op_count` increments by 1 on each output transfer, 8-bit wrap (255 → 0).
- Timeout (macro-controlled, see Configuration):
  - An idle counter, width clog2(TIMEOUT+1), clears on any accepted beat and on entering S_B or S_C.
  - In S_B or S_C it increments each cycle with no accepted beat.
  - On the edge where it would reach TIMEOUT: state → S_A, counter clears, `err` = 1 for exactly the next cycle.
  - No counting in S_A or S_OUT.
- Simultaneous beat and timeout edge: the beat wins, the counter clears and no `err` is raised.
- Reset mid-group or mid-hold discards all state immediately.

## Timing
- Reset values: state S_A, `in_ready` 1, `out_valid` 0, `out_1` 0, `out_2` 0, `out_3` 0, `err` 0, `op_count` 0, idle counter 0.
- Latency: `out_valid` rises on the cycle after beat C is accepted.
- Throughput: one operand set per 3 cycles with continuous `in_valid` and `out_ready`. The beat-A capture overlaps the output transfer.
- `in_ready` has a combinational path from `out_ready`. All other outputs are registered.
- `err` fires TIMEOUT cycles after the last accepted beat of a stalled partial group.

## Configuration
- `OPERAND_LOADER_TIMEOUT_EN` defined:
  - The idle counter and drop logic are compiled in, as described above.
- `OPERAND_LOADER_TIMEOUT_EN` undefined:
  - No counter is built and `err` is tied to 0.
  - A partial group waits in S_B or S_C indefinitely.
  - `TIMEOUT` is unused.

## Test plan
- Reset then beats 0xA, 0x5, 0x1 with `out_ready`=1: `out_valid` high one cycle after the third beat, with `out_1`=0xA, `out_2`=0x5, `out_3`=1; `op_count`=1 after the transfer.
- Back-to-back groups (0x3,0xC,0x0), (0xF,0x1,0x1) with `in_valid` and `out_ready` held high: two transfers 3 cycles apart, `in_ready` never low, `op_count`=2.
- Group 0x6,0x9,0x1 with `out_ready`=0 for 5 cycles: outputs hold 0x6/0x9/1, `in_ready`=0 and an offered beat 0x2 is not taken; when `out_ready` rises, the transfer and the 0x2 capture occur on the same edge.
- With the macro on, beat 0x7 followed by 15 idle cycles: `err` pulses one cycle, state is S_A; next beats 0x4,0x8,0x0 yield `out_1`=0x4, not 0x7.
- With the macro on, beat 0x7, 14 idle cycles, then beat 0x2 on the 15th: no `err`, and the group completes normally.
- Assert `rst` in S_C: all outputs return to reset values asynchronously; `op_count` wrap is checked separately with 256 transfers returning it to 0.
